// File: rtl/uart_frame_parser.sv
// Framed-packet parser behind the UART receiver: HEADER, LEN, payload, checksum.
// Verified payloads are replayed on a valid/ready/last stream; optional FRAME_TIMEOUT_EN adds an inter-byte timeout.
//
// state     | meaning
// S_HDR     | hunting for the header byte, accumulator cleared
// S_LEN     | waiting for the length byte
// S_PAYLOAD | buffering payload bytes
// S_CSUM    | waiting for the checksum byte
// S_OUT     | draining the verified payload downstream
module uart_frame_parser #(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  HEADER         = 8'h55,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HDR, S_LEN, S_PAYLOAD, S_CSUM, S_OUT} state_t;

    state_t     state;
    logic [7:0] len;
    logic [7:0] len_m1;
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [7:0] sum;
    logic       accept;
    logic [7:0] mem [2**AW];

`ifdef FRAME_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_cnt;
`endif

    assign len_m1    = len - 8'd1;
    assign in_ready  = (state != S_OUT);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_OUT);
    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign out_last  = out_valid && (rd_ptr == len_m1);

    // Payload storage carries no reset; only bytes of the current frame are ever read.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && accept)
            mem[wr_ptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HDR;
            len       <= 8'd0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            sum       <= 8'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
`ifdef FRAME_TIMEOUT_EN
            tmo_cnt   <= 32'd0;
`endif
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_HDR: begin
                    sum <= 8'd0;
                    if (accept && in_data == HEADER)
                        state <= S_LEN;
                end
                S_LEN: begin
                    if (accept) begin
                        len <= in_data;
                        sum <= in_data;
                        if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b01;
                            state     <= S_HDR;
                        end else begin
                            wr_ptr <= 8'd0;
                            state  <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 8'd1;
                        sum    <= sum + in_data;
                        if (wr_ptr == len_m1)
                            state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == sum) begin
                            frame_ok <= 1'b1;
                            rd_ptr   <= 8'd0;
                            state    <= S_OUT;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b10;
                            state     <= S_HDR;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (rd_ptr == len_m1)
                            state <= S_HDR;
                        else
                            rd_ptr <= rd_ptr + 8'd1;
                    end
                end
                default: state <= S_HDR;
            endcase
`ifdef FRAME_TIMEOUT_EN
            // Only reachable with no byte accepted, so it never collides with the LEN/CSUM error paths.
            if (state == S_LEN || state == S_PAYLOAD || state == S_CSUM) begin
                if (accept) begin
                    tmo_cnt <= 32'd0;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt   <= 32'd0;
                    frame_err <= 1'b1;
                    err_code  <= 2'b11;
                    state     <= S_HDR;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
            end else begin
                tmo_cnt <= 32'd0;
            end
`endif
        end
    end

endmodule
